crypto_wb_stage: RTL and testbench
==================================

Name: crypto_wb_stage

Overview:
- Writeback stage directly downstream of the execution block. It consumes the EX result (ALU/multdiv/SHA2/AES/Kyber) and the LSU load response, and drives the register-file write port.
- One-entry stage: FSM tracks an in-flight instruction, stalls EX while a load is outstanding, and reports completion.
- Keeps saturating retirement counters per crypto instruction class for performance profiling.

Parameters:
- CntWidth, 32, width of each per-class retirement counter.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous reset, active-high.
- en_wb_i  in  1  EX presents a completed instruction (ex_valid qualified).
- ready_wb_o  out  1  stage can accept an instruction this cycle.
- instr_is_load_i  in  1  instruction is a load; data arrives via LSU response.
- instr_class_i  in  2  0=base, 1=SHA2, 2=AES, 3=Kyber.
- rf_we_i  in  1  instruction writes rd.
- rf_waddr_i  in  5  destination register index.
- rf_wdata_i  in  32  EX result (ignored for loads).
- lsu_resp_valid_i  in  1  load data/error valid this cycle.
- lsu_rdata_i  in  32  load data.
- lsu_err_i  in  1  load bus error.
- rf_we_o  out  1  register-file write enable; also the forwarding-valid source.
- rf_waddr_o  out  5  write address.
- rf_wdata_o  out  32  write data.
- instr_done_o  out  1  one-cycle pulse per retired instruction.
- load_err_o  out  1  one-cycle pulse on a faulting load.
- cnt_clr_i  in  1  synchronous clear of all counters.
- cnt_sha2_o  out  CntWidth  retired SHA2 count.
- cnt_aes_o  out  CntWidth  retired AES count.
- cnt_kyber_o  out  CntWidth  retired Kyber count.

Behaviour:
- Reset (rst_i=1 at an edge): state=IDLE, captured fields and counters cleared. All outputs 0 except ready_wb_o=1. Reset mid-WAIT_LOAD abandons the load. A late lsu_resp_valid_i after reset is ignored.
- Accept condition: en_wb_i && ready_wb_o. On accept, register class, we, waddr, wdata and is_load.
  - Next state: WAIT_LOAD if is_load, else WB.
  - No accept: next state IDLE, except WAIT_LOAD, which stays until a response arrives.
- States:
  - IDLE: no outputs asserted; ready_wb_o=1.
  - WB: instr_done_o=1. rf_we_o = we_q && waddr_q!=0. rf_waddr_o=waddr_q, rf_wdata_o=wdata_q. ready_wb_o=1, so back-to-back accepts give one retirement per cycle (throughput 1, latency 1 cycle from accept).
  - WAIT_LOAD: outputs stay low until lsu_resp_valid_i.
    - Response cycle, no error: instr_done_o=1; rf_we_o = we_q && waddr_q!=0 && !lsu_err_i; rf_wdata_o = lsu_rdata_i (combinational pass-through).
    - Response cycle, error: load_err_o=1 and no RF write.
    - ready_wb_o = lsu_resp_valid_i, so a new instruction may be accepted in the response cycle.
    - Zero-wait-state load: response in the first WAIT_LOAD cycle gives 1-cycle latency.
- rf_waddr_o is driven 0 and rf_wdata_o is driven 0 whenever rf_we_o=0. No X on outputs.
- lsu_resp_valid_i outside WAIT_LOAD is a protocol violation. It is ignored, and an assertion flags it.
- Writes to x0 are suppressed, but instr_done_o still pulses.
- Counters: on instr_done_o, increment the counter selected by class_q (class 0 increments nothing).
  - Counters saturate at 2^CntWidth-1 and never wrap.
  - cnt_clr_i has priority over a same-cycle increment; the result is 0.
  - Counter outputs are registered values.
- Assertions:
  - onehot0 of {WB, WAIT_LOAD}.
  - rf_we_o implies instr_done_o.
  - en_wb_i && !ready_wb_o must hold en_wb_i and fields stable until accepted (EX-side requirement).

Test Plan:
- Back-to-back ALU ops: accept x5←0x1234 then x6←0xDEAD on consecutive cycles -> rf_we_o high 2 consecutive cycles with (5,0x1234),(6,0xDEAD); instr_done_o pulses twice.
- Load with 3-cycle LSU delay to x7, data 0xCAFEF00D, second instr offered meanwhile -> ready_wb_o low for 2 cycles, write (7,0xCAFEF00D) in the response cycle, second instr accepted that same cycle and written the next cycle.
- Load error: lsu_err_i=1 with response -> load_err_o=1, instr_done_o=1, rf_we_o=0; x0 ALU write -> rf_we_o=0, instr_done_o=1.
- Counters: retire 3 SHA2, 2 AES, 1 Kyber, 4 base -> cnt_sha2_o=3, cnt_aes_o=2, cnt_kyber_o=1. cnt_clr_i coincident with a Kyber retire -> cnt_kyber_o=0.
- Saturation with CntWidth=4: 17 AES retirements -> cnt_aes_o=15.
- rst_i asserted in WAIT_LOAD, LSU response arrives the following cycle -> no write, no done pulse, state IDLE, ready_wb_o=1, counters 0.

Source files
------------

// File: rtl/crypto_wb_stage_if.sv
// Bundle of the EX hand-off, LSU load response, register-file write and profiling
// counter signals seen by the writeback stage. Names are taken from the stage's side.
interface crypto_wb_stage_if #(
  parameter int unsigned CntWidth = 32
);
  logic                en_wb_i;
  logic                ready_wb_o;
  logic                instr_is_load_i;
  logic [1:0]          instr_class_i;
  logic                rf_we_i;
  logic [4:0]          rf_waddr_i;
  logic [31:0]         rf_wdata_i;
  logic                lsu_resp_valid_i;
  logic [31:0]         lsu_rdata_i;
  logic                lsu_err_i;
  logic                rf_we_o;
  logic [4:0]          rf_waddr_o;
  logic [31:0]         rf_wdata_o;
  logic                instr_done_o;
  logic                load_err_o;
  logic                cnt_clr_i;
  logic [CntWidth-1:0] cnt_sha2_o;
  logic [CntWidth-1:0] cnt_aes_o;
  logic [CntWidth-1:0] cnt_kyber_o;

  modport slave (
    input  en_wb_i, instr_is_load_i, instr_class_i, rf_we_i, rf_waddr_i, rf_wdata_i,
           lsu_resp_valid_i, lsu_rdata_i, lsu_err_i, cnt_clr_i,
    output ready_wb_o, rf_we_o, rf_waddr_o, rf_wdata_o, instr_done_o, load_err_o,
           cnt_sha2_o, cnt_aes_o, cnt_kyber_o
  );

  modport master (
    output en_wb_i, instr_is_load_i, instr_class_i, rf_we_i, rf_waddr_i, rf_wdata_i,
           lsu_resp_valid_i, lsu_rdata_i, lsu_err_i, cnt_clr_i,
    input  ready_wb_o, rf_we_o, rf_waddr_o, rf_wdata_o, instr_done_o, load_err_o,
           cnt_sha2_o, cnt_aes_o, cnt_kyber_o
  );
endinterface

// File: rtl/crypto_wb_stage.sv
// One-entry writeback stage: retires EX results or waits for the LSU load response,
// drives the register-file write port and keeps saturating per-crypto-class retire counts.
module crypto_wb_stage #(
  parameter int unsigned CntWidth = 32
) (
  input logic              clk_i,
  input logic              rst_i,
  crypto_wb_stage_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, WB = 2'd1, WAIT_LOAD = 2'd2} state_e;

  state_e              state_q, state_d;
  logic [1:0]          class_q;
  logic                we_q;
  logic [4:0]          waddr_q;
  logic [31:0]         wdata_q;
  logic [CntWidth-1:0] cnt_sha2_q, cnt_aes_q, cnt_kyber_q;

  logic resp, ready, accept, done, we_out;

  function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    resp    = (state_q == WAIT_LOAD) && bus.lsu_resp_valid_i;
    ready   = (state_q != WAIT_LOAD) || bus.lsu_resp_valid_i;
    accept  = bus.en_wb_i && ready;
    done    = (state_q == WB) || resp;
    we_out  = we_q && (waddr_q != 5'd0) &&
              ((state_q == WB) || (resp && !bus.lsu_err_i));
    state_d = IDLE;
    if (accept) begin
      state_d = bus.instr_is_load_i ? WAIT_LOAD : WB;
    end else if ((state_q == WAIT_LOAD) && !bus.lsu_resp_valid_i) begin
      state_d = WAIT_LOAD;
    end
  end

  // Load data is passed straight through in the response cycle; address/data are zeroed when not writing
  assign bus.ready_wb_o   = ready;
  assign bus.rf_we_o      = we_out;
  assign bus.rf_waddr_o   = we_out ? waddr_q : 5'd0;
  assign bus.rf_wdata_o   = !we_out ? 32'd0 : ((state_q == WB) ? wdata_q : bus.lsu_rdata_i);
  assign bus.instr_done_o = done;
  assign bus.load_err_o   = resp && bus.lsu_err_i;
  assign bus.cnt_sha2_o   = cnt_sha2_q;
  assign bus.cnt_aes_o    = cnt_aes_q;
  assign bus.cnt_kyber_o  = cnt_kyber_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      class_q <= 2'd0;
      we_q    <= 1'b0;
      waddr_q <= 5'd0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        class_q <= bus.instr_class_i;
        we_q    <= bus.rf_we_i;
        waddr_q <= bus.rf_waddr_i;
        wdata_q <= bus.rf_wdata_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || bus.cnt_clr_i) begin
      cnt_sha2_q  <= '0;
      cnt_aes_q   <= '0;
      cnt_kyber_q <= '0;
    end else if (done) begin
      case (class_q)
        2'd1:    cnt_sha2_q  <= sat_inc(cnt_sha2_q);
        2'd2:    cnt_aes_q   <= sat_inc(cnt_aes_q);
        2'd3:    cnt_kyber_q <= sat_inc(cnt_kyber_q);
        default: ;
      endcase
    end
  end

  a_state_onehot0: assert property (@(posedge clk_i)
    $onehot0({state_q == WB, state_q == WAIT_LOAD}));

  a_we_implies_done: assert property (@(posedge clk_i) disable iff (rst_i)
    bus.rf_we_o |-> bus.instr_done_o);

  // A response landing right after reset belongs to an abandoned load and is tolerated
  a_resp_only_in_wait: assert property (@(posedge clk_i) disable iff (rst_i)
    (bus.lsu_resp_valid_i && (state_q != WAIT_LOAD)) |-> $past(rst_i));

  a_ex_holds_when_stalled: assert property (@(posedge clk_i) disable iff (rst_i)
    (bus.en_wb_i && !bus.ready_wb_o) |=>
      (bus.en_wb_i && $stable({bus.instr_is_load_i, bus.instr_class_i, bus.rf_we_i,
                               bus.rf_waddr_i, bus.rf_wdata_i})));
endmodule

// File: tb/tb_crypto_wb_stage.sv
// Directed bench for crypto_wb_stage: per-cycle vector table for the writeback/load flow,
// plus hand-written sequences for counters, clear priority, saturation and reset mid-load.
module tb_crypto_wb_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  crypto_wb_stage_if #(.CntWidth(32)) bus ();
  crypto_wb_stage_if #(.CntWidth(4))  bus4 ();

  crypto_wb_stage #(.CntWidth(32)) dut  (.clk_i(clk), .rst_i(rst), .bus(bus));
  crypto_wb_stage #(.CntWidth(4))  dut4 (.clk_i(clk), .rst_i(rst), .bus(bus4));

  always #5 clk = ~clk;

  typedef struct {
    logic        en, ld;
    logic [1:0]  cls;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        rv;
    logic [31:0] rd;
    logic        err;
    logic        e_rdy, e_we;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    logic        e_done, e_lerr;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic en, input logic ld, input logic [1:0] cls, input logic we,
                       input logic [4:0] wa, input logic [31:0] wd, input logic rv,
                       input logic [31:0] rd, input logic err);
    bus.en_wb_i          = en;
    bus.instr_is_load_i  = ld;
    bus.instr_class_i    = cls;
    bus.rf_we_i          = we;
    bus.rf_waddr_i       = wa;
    bus.rf_wdata_i       = wd;
    bus.lsu_resp_valid_i = rv;
    bus.lsu_rdata_i      = rd;
    bus.lsu_err_i        = err;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 2'd0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string tag, input logic rdy, input logic we, input logic [4:0] wa,
                          input logic [31:0] wd, input logic done, input logic lerr);
    chk({tag, ".ready"}, {31'd0, bus.ready_wb_o}, {31'd0, rdy});
    chk({tag, ".rf_we"}, {31'd0, bus.rf_we_o}, {31'd0, we});
    chk({tag, ".rf_waddr"}, {27'd0, bus.rf_waddr_o}, {27'd0, wa});
    chk({tag, ".rf_wdata"}, bus.rf_wdata_o, wd);
    chk({tag, ".done"}, {31'd0, bus.instr_done_o}, {31'd0, done});
    chk({tag, ".load_err"}, {31'd0, bus.load_err_o}, {31'd0, lerr});
  endtask

  int cls_seq [10] = '{1, 0, 2, 1, 0, 3, 2, 0, 1, 0};

  initial begin
    //           en    ld    cls   we    wa     wd             rv    rd             err  | rdy   we    wa     wd             done  lerr
    tbl[0]  = '{1'b1, 1'b0, 2'd0, 1'b1, 5'd5,  32'h0000_1234, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 5'd0,  32'h0,         1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 2'd0, 1'b1, 5'd6,  32'h0000_DEAD, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 5'd5,  32'h0000_1234, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 2'd0, 1'b0, 5'd0,  32'h0,         1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 5'd6,  32'h0000_DEAD, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 2'd0, 1'b1, 5'd7,  32'h0,         1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 5'd0,  32'h0,         1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 2'd0, 1'b1, 5'd8,  32'h0000_8888, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 5'd0,  32'h0,         1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 2'd0, 1'b1, 5'd8,  32'h0000_8888, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 5'd0,  32'h0,         1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 2'd0, 1'b1, 5'd8,  32'h0000_8888, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b1, 1'b1, 5'd7,  32'hCAFE_F00D, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 2'd0, 1'b0, 5'd0,  32'h0,         1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 5'd8,  32'h0000_8888, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 2'd0, 1'b1, 5'd9,  32'h0,         1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 5'd0,  32'h0,         1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 2'd0, 1'b0, 5'd0,  32'h0,         1'b1, 32'h1234_5678, 1'b1, 1'b1, 1'b0, 5'd0,  32'h0,         1'b1, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 2'd0, 1'b1, 5'd0,  32'h0000_FFFF, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 5'd0,  32'h0,         1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 2'd0, 1'b0, 5'd0,  32'h0,         1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 5'd0,  32'h0,         1'b1, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 2'd0, 1'b1, 5'd10, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 5'd0,  32'h0,         1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 2'd0, 1'b0, 5'd0,  32'h0,         1'b1, 32'hA5A5_A5A5, 1'b0, 1'b1, 1'b1, 5'd10, 32'hA5A5_A5A5, 1'b1, 1'b0};
    tbl[14] = '{1'b1, 1'b0, 2'd0, 1'b0, 5'd11, 32'h0000_5555, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 5'd0,  32'h0,         1'b0, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 2'd0, 1'b0, 5'd0,  32'h0,         1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 5'd0,  32'h0,         1'b1, 1'b0};
    tbl[16] = '{1'b0, 1'b0, 2'd0, 1'b0, 5'd0,  32'h0,         1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 5'd0,  32'h0,         1'b0, 1'b0};

    idle();
    bus.cnt_clr_i = 1'b0;
    bus4.en_wb_i = 1'b0; bus4.instr_is_load_i = 1'b0; bus4.instr_class_i = 2'd0;
    bus4.rf_we_i = 1'b0; bus4.rf_waddr_i = 5'd0; bus4.rf_wdata_i = 32'd0;
    bus4.lsu_resp_valid_i = 1'b0; bus4.lsu_rdata_i = 32'd0; bus4.lsu_err_i = 1'b0;
    bus4.cnt_clr_i = 1'b0;

    // Reset state
    tick(); tick();
    chk_outs("reset", 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    chk("reset.cnt_sha2", bus.cnt_sha2_o, 32'd0);
    chk("reset.cnt_aes", bus.cnt_aes_o, 32'd0);
    chk("reset.cnt_kyber", bus.cnt_kyber_o, 32'd0);
    rst = 1'b0;
    tick();

    // Per-cycle vector table
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].en, tbl[i].ld, tbl[i].cls, tbl[i].we, tbl[i].wa, tbl[i].wd,
            tbl[i].rv, tbl[i].rd, tbl[i].err);
      #4;
      chk_outs($sformatf("vec%0d", i), tbl[i].e_rdy, tbl[i].e_we, tbl[i].e_wa,
               tbl[i].e_wd, tbl[i].e_done, tbl[i].e_lerr);
      tick();
    end
    chk("base_only.cnt_sha2", bus.cnt_sha2_o, 32'd0);

    // Class counters: 3 SHA2, 2 AES, 1 Kyber, 4 base, back-to-back
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, cls_seq[i][1:0], 1'b1, 5'd1, 32'(i), 1'b0, 32'd0, 1'b0);
      tick();
    end
    idle();
    tick();
    chk("cnt.sha2", bus.cnt_sha2_o, 32'd3);
    chk("cnt.aes", bus.cnt_aes_o, 32'd2);
    chk("cnt.kyber", bus.cnt_kyber_o, 32'd1);

    // Clear coincident with a Kyber retirement
    drive(1'b1, 1'b0, 2'd3, 1'b1, 5'd2, 32'd9, 1'b0, 32'd0, 1'b0);
    tick();
    idle();
    bus.cnt_clr_i = 1'b1;
    #4;
    chk("clr.done", {31'd0, bus.instr_done_o}, 32'd1);
    tick();
    bus.cnt_clr_i = 1'b0;
    chk("clr.kyber", bus.cnt_kyber_o, 32'd0);
    chk("clr.sha2", bus.cnt_sha2_o, 32'd0);
    chk("clr.aes", bus.cnt_aes_o, 32'd0);

    // Reset while waiting on a load, response arrives right after
    drive(1'b1, 1'b0, 2'd1, 1'b1, 5'd3, 32'd1, 1'b0, 32'd0, 1'b0);
    tick();
    idle();
    tick();
    chk("pre_rst.sha2", bus.cnt_sha2_o, 32'd1);
    drive(1'b1, 1'b1, 2'd2, 1'b1, 5'd12, 32'd0, 1'b0, 32'd0, 1'b0);
    tick();
    idle();
    rst = 1'b1;
    #4;
    chk("pre_rst.ready", {31'd0, bus.ready_wb_o}, 32'd0);
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, 2'd0, 1'b0, 5'd0, 32'd0, 1'b1, 32'h0000_BEEF, 1'b0);
    #4;
    chk_outs("rst_wait", 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    chk("rst_wait.sha2", bus.cnt_sha2_o, 32'd0);
    tick();
    idle();
    chk("rst_wait.aes_after", bus.cnt_aes_o, 32'd0);
    #4;
    chk_outs("rst_idle", 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    tick();

    // Saturation on the 4-bit counter instance: 17 AES retirements
    for (int i = 0; i < 17; i++) begin
      bus4.en_wb_i = 1'b1; bus4.instr_class_i = 2'd2;
      bus4.rf_we_i = 1'b1; bus4.rf_waddr_i = 5'd4; bus4.rf_wdata_i = 32'(i);
      tick();
    end
    bus4.en_wb_i = 1'b0;
    tick();
    chk("sat.aes", {28'd0, bus4.cnt_aes_o}, 32'd15);
    chk("sat.sha2", {28'd0, bus4.cnt_sha2_o}, 32'd0);
    tick();
    chk("sat.aes_hold", {28'd0, bus4.cnt_aes_o}, 32'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
